sync_req_arbiter: RTL

Round-robin arbiter that shares one single-clock resource among NUM_REQ requesters living in foreign or asynchronous clock domains. Each requester uses a four-phase level handshake (req/ack); the block synchronizes every req line internally with a `synchronizer` instance, grants one requester at a time, and sequences the shared resource through a start/done handshake. It sits on the `clk` side of the clock-domain boundary, directly in front of the shared resource.

---
 rtl/sync_req_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter granting one clk-domain resource to asynchronous four-phase requesters.
// Optional WAIT watchdog enabled by defining SYNC_REQ_ARBITER_TIMEOUT_EN.

module synchronizer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Plain flop chain with no reset so it can sit on the async boundary.
    logic [WIDTH-1:0] chain [DEPTH];

    always_ff @(posedge clk) begin
        chain[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
            chain[i] <= chain[i-1];
        end
    end

    assign q = chain[DEPTH-1];

endmodule

module sync_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int SYNC_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDW           = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_async,
    output logic [NUM_REQ-1:0] ack,
    output logic               res_start,
    output logic [IDW-1:0]     res_sel,
    input  logic               res_done,
    output logic               busy,
    output logic               timeout_err
);

    localparam int SCW = $clog2(SYNC_DEPTH + 1);

    typedef enum logic [2:0] {SETTLE, IDLE, START, WAIT, RELEASE} state_t;

    state_t               state;
    state_t               state_next;
    logic [NUM_REQ-1:0]   req_s;
    logic [SCW-1:0]       settle_cnt;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       winner;
    logic                 any_req;
    logic                 expired;

    if (NUM_REQ < 2 || NUM_REQ > 16 || SYNC_DEPTH < 2 || SYNC_DEPTH > 9 || TIMEOUT_CYCLES < 1)
    begin : g_bad_params
        $error("sync_req_arbiter: parameter out of range");
    end

    synchronizer #(.DEPTH(SYNC_DEPTH), .WIDTH(NUM_REQ)) u_req_sync (
        .clk (clk),
        .d   (req_async),
        .q   (req_s)
    );

    assign any_req = |req_s;

    // Scan downward so the nearest set bit after ptr is the last one written.
    always_comb begin
        winner = ptr;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_s[IDW'((int'(ptr) + i) % NUM_REQ)]) begin
                winner = IDW'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SETTLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SETTLE:  if (settle_cnt == SCW'(SYNC_DEPTH)) state_next = IDLE;
            IDLE:    if (any_req) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (res_done || expired) state_next = RELEASE;
            RELEASE: if (!req_s[res_sel]) state_next = IDLE;
            default: state_next = SETTLE;
        endcase
    end

    // Grant bookkeeping: res_sel latches on grant, ptr advances only on release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            ptr        <= IDW'(NUM_REQ - 1);
            res_sel    <= '0;
            ack        <= '0;
        end else begin
            if (state == SETTLE && settle_cnt != SCW'(SYNC_DEPTH)) begin
                settle_cnt <= settle_cnt + SCW'(1);
            end
            if (state == IDLE && any_req) begin
                res_sel <= winner;
            end
            if (state == WAIT && (res_done || expired)) begin
                ack <= NUM_REQ'(1) << res_sel;
            end
            if (state == RELEASE && !req_s[res_sel]) begin
                ack <= '0;
                ptr <= res_sel;
            end
        end
    end

`ifdef SYNC_REQ_ARBITER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] watchdog;
    logic           timeout_q;

    // Expiry is the cycle whose increment would bring the count to the limit.
    assign expired = (state == WAIT) && (watchdog == WDW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            watchdog  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expired && !res_done;
            if (state == START) begin
                watchdog <= '0;
            end else if (state == WAIT) begin
                watchdog <= watchdog + WDW'(1);
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign expired     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign res_start = (state == START);
    assign busy      = (state != IDLE);

endmodule
